// File: rtl/mem_wb_stage_if.sv
// MEM->WB stage bundle: MEM-stage control/data into the stage, registered WB results out.
// The master side drives the MEM signals and observes the WB results.
interface mem_wb_stage_if;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic [31:0] mem_alu;
    logic [2:0]  mem_ld_op;
    logic [1:0]  mem_wsel;
    logic [4:0]  mem_rd;
    logic        mem_rfwe;

    logic        wb_valid;
    logic [31:0] wb_pc;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        wb_rfwe;
    logic        wb_addr_err;

    modport master (
        output mem_valid, mem_pc, mem_addr, mem_rdata, mem_alu,
               mem_ld_op, mem_wsel, mem_rd, mem_rfwe,
        input  wb_valid, wb_pc, wb_rd, wb_wd, wb_rfwe, wb_addr_err
    );

    modport slave (
        input  mem_valid, mem_pc, mem_addr, mem_rdata, mem_alu,
               mem_ld_op, mem_wsel, mem_rd, mem_rfwe,
        output wb_valid, wb_pc, wb_rd, wb_wd, wb_rfwe, wb_addr_err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: aligns/extends load data, picks the writeback value,
// flags misaligned loads and registers everything for the register file.
module mem_wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           flush,
    mem_wb_stage_if.slave  bus
);

    localparam logic [2:0] LD_LW  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LHU = 3'b010;
    localparam logic [2:0] LD_LB  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;

    // Extract and extend the addressed lane; unknown load ops behave as LW.
    function automatic logic [31:0] load_extract(
        input logic [2:0]  ld_op,
        input logic [1:0]  boff,
        input logic [31:0] rdata
    );
        logic [15:0] half;
        logic [7:0]  lane;
        half = boff[1] ? rdata[31:16] : rdata[15:0];
        case (boff)
            2'd0:    lane = rdata[7:0];
            2'd1:    lane = rdata[15:8];
            2'd2:    lane = rdata[23:16];
            2'd3:    lane = rdata[31:24];
            default: lane = rdata[7:0];
        endcase
        case (ld_op)
            LD_LH:   load_extract = {{16{half[15]}}, half};
            LD_LHU:  load_extract = {16'h0000, half};
            LD_LB:   load_extract = {{24{lane[7]}}, lane};
            LD_LBU:  load_extract = {24'h00_0000, lane};
            default: load_extract = rdata;
        endcase
    endfunction

    // Word loads need a 4-byte aligned address, halfword loads 2-byte; bytes never fault.
    function automatic logic load_misaligned(
        input logic [2:0] ld_op,
        input logic [1:0] boff
    );
        case (ld_op)
            LD_LH, LD_LHU:  load_misaligned = boff[0];
            LD_LB, LD_LBU:  load_misaligned = 1'b0;
            default:        load_misaligned = (boff != 2'd0);
        endcase
    endfunction

    logic [31:0] load_val_s;
    logic [31:0] sel_s;
    logic        err_s;
    logic        rfwe_s;

    logic        wb_valid_r;
    logic [31:0] wb_pc_r;
    logic [4:0]  wb_rd_r;
    logic [31:0] wb_wd_r;
    logic        wb_rfwe_r;
    logic        wb_addr_err_r;

    // Writeback value select, misalignment detect and write-enable qualification.
    always_comb begin
        load_val_s = load_extract(bus.mem_ld_op, bus.mem_addr[1:0], bus.mem_rdata);
        sel_s      = bus.mem_alu;
        err_s      = 1'b0;
        case (bus.mem_wsel)
            2'b01: begin
                sel_s = load_val_s;
                err_s = load_misaligned(bus.mem_ld_op, bus.mem_addr[1:0]);
            end
            2'b10:   sel_s = bus.mem_pc + 32'd8;
            default: sel_s = bus.mem_alu;
        endcase
        rfwe_s = bus.mem_valid & bus.mem_rfwe & (bus.mem_rd != 5'd0) & ~err_s;
    end

    // WB register bank: reset and flush both load a bubble; stall holds everything.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wb_valid_r    <= 1'b0;
            wb_pc_r       <= RESET_PC;
            wb_rd_r       <= 5'd0;
            wb_wd_r       <= 32'd0;
            wb_rfwe_r     <= 1'b0;
            wb_addr_err_r <= 1'b0;
        end else if (!stall) begin
            wb_valid_r    <= bus.mem_valid;
            wb_pc_r       <= bus.mem_pc;
            wb_rd_r       <= bus.mem_rd;
            wb_wd_r       <= sel_s;
            wb_rfwe_r     <= rfwe_s;
            wb_addr_err_r <= bus.mem_valid & err_s;
        end
    end

    assign bus.wb_valid    = wb_valid_r;
    assign bus.wb_pc       = wb_pc_r;
    assign bus.wb_rd       = wb_rd_r;
    assign bus.wb_wd       = wb_wd_r;
    assign bus.wb_rfwe     = wb_rfwe_r;
    assign bus.wb_addr_err = wb_addr_err_r;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed and random MEM traffic, expected WB
// contents pushed into a scoreboard by the driver and checked by a separate monitor.
module tb_mem_wb_stage;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wd;
        logic        rfwe;
        logic        err;
    } wb_t;

    logic clk = 1'b0;
    logic reset, stall, flush;
    int   checks   = 0;
    int   failures = 0;
    wb_t  exp_q[$];
    wb_t  model_state;

    mem_wb_stage_if bus ();

    mem_wb_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: what the WB slot must hold after the coming edge.
    function automatic wb_t model(
        input logic rst, input logic fl, input logic st, input logic v,
        input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rdata,
        input logic [31:0] alu, input logic [2:0] op, input logic [1:0] ws,
        input logic [4:0] rd, input logic we, input wb_t prev
    );
        wb_t r;
        int unsigned b;
        logic [7:0]  by;
        logic [15:0] hw;
        logic [31:0] lv;
        logic        misal;
        if (rst || fl) begin
            r = '{valid: 1'b0, pc: 32'h0000_3000, rd: 5'd0, wd: 32'd0, rfwe: 1'b0, err: 1'b0};
            return r;
        end
        if (st) return prev;
        b  = int'(addr) & 3;
        by = 8'((rdata >> (8 * b)) & 32'hFF);
        hw = 16'((rdata >> (16 * (b / 2))) & 32'hFFFF);
        case (op)
            3'd1:    lv = 32'(signed'(hw));
            3'd2:    lv = 32'(hw);
            3'd3:    lv = 32'(signed'(by));
            3'd4:    lv = 32'(by);
            default: lv = rdata;
        endcase
        if (op == 3'd3 || op == 3'd4)      misal = 1'b0;
        else if (op == 3'd1 || op == 3'd2) misal = (b % 2) != 0;
        else                               misal = (b != 0);
        misal = misal && (ws == 2'd1);
        r.valid = v;
        r.pc    = pc;
        r.rd    = rd;
        r.wd    = (ws == 2'd1) ? lv : (ws == 2'd2) ? pc + 32'd8 : alu;
        r.rfwe  = v && we && (rd != 5'd0) && !misal;
        r.err   = v && misal;
        return r;
    endfunction

    task automatic issue(
        input logic rst, input logic fl, input logic st, input logic v,
        input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] rdata,
        input logic [31:0] alu, input logic [2:0] op, input logic [1:0] ws,
        input logic [4:0] rd, input logic we
    );
        @(negedge clk);
        reset = rst; flush = fl; stall = st;
        bus.mem_valid = v;  bus.mem_pc = pc;   bus.mem_addr = addr;
        bus.mem_rdata = rdata; bus.mem_alu = alu; bus.mem_ld_op = op;
        bus.mem_wsel = ws; bus.mem_rd = rd; bus.mem_rfwe = we;
        model_state = model(rst, fl, st, v, pc, addr, rdata, alu, op, ws, rd, we, model_state);
        exp_q.push_back(model_state);
    endtask

    task automatic issue_rand(input logic rst, input logic fl, input logic st);
        issue(rst, fl, st, 1'($urandom), $urandom, $urandom, $urandom, $urandom,
              3'($urandom_range(0, 7)), 2'($urandom), 5'($urandom), 1'($urandom));
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Wait past the next edge, then compare a spec constant directly.
    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every cycle the WB slot is compared to the oldest expectation.
    initial begin : monitor
        wb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.wb_valid !== e.valid || bus.wb_pc !== e.pc || bus.wb_rd !== e.rd ||
                    bus.wb_wd !== e.wd || bus.wb_rfwe !== e.rfwe || bus.wb_addr_err !== e.err) begin
                    failures++;
                    $display("FAIL wb_slot @%0t: got v=%b pc=%h rd=%0d wd=%h we=%b err=%b expected v=%b pc=%h rd=%0d wd=%h we=%b err=%b",
                             $time, bus.wb_valid, bus.wb_pc, bus.wb_rd, bus.wb_wd, bus.wb_rfwe,
                             bus.wb_addr_err, e.valid, e.pc, e.rd, e.wd, e.rfwe, e.err);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        model_state = '{valid: 1'b0, pc: 32'h0000_3000, rd: 5'd0, wd: 32'd0, rfwe: 1'b0, err: 1'b0};
        reset = 1'b1; flush = 1'b0; stall = 1'b0;
        // Reset with random MEM inputs.
        issue_rand(1'b1, 1'b0, 1'b0);
        issue_rand(1'b1, 1'b0, 1'b0);
        after_edge();
        chk32("reset_pc", bus.wb_pc, 32'h0000_3000);
        chk32("reset_valid", 32'(bus.wb_valid), 32'd0);

        // Byte loads from lane 3.
        issue(0, 0, 0, 1, 32'h100, 32'h0000_0003, 32'h80FF_1234, 32'h0, 3'd3, 2'd1, 5'd8, 1);
        after_edge();
        chk32("lb_wd", bus.wb_wd, 32'hFFFF_FF80);
        chk32("lb_rfwe", 32'(bus.wb_rfwe), 32'd1);
        issue(0, 0, 0, 1, 32'h104, 32'h0000_0003, 32'h80FF_1234, 32'h0, 3'd4, 2'd1, 5'd8, 1);
        after_edge();
        chk32("lbu_wd", bus.wb_wd, 32'h0000_0080);

        // Halfword loads and a misaligned word load.
        issue(0, 0, 0, 1, 32'h108, 32'h0000_0012, 32'h8001_7FFF, 32'h0, 3'd1, 2'd1, 5'd9, 1);
        after_edge();
        chk32("lh_wd", bus.wb_wd, 32'hFFFF_8001);
        issue(0, 0, 0, 1, 32'h10C, 32'h0000_0010, 32'h8001_7FFF, 32'h0, 3'd2, 2'd1, 5'd9, 1);
        after_edge();
        chk32("lhu_wd", bus.wb_wd, 32'h0000_7FFF);
        issue(0, 0, 0, 1, 32'h110, 32'h0000_0012, 32'h8001_7FFF, 32'h0, 3'd0, 2'd1, 5'd9, 1);
        after_edge();
        chk32("lw_mis_err", 32'(bus.wb_addr_err), 32'd1);
        chk32("lw_mis_rfwe", 32'(bus.wb_rfwe), 32'd0);
        issue(0, 0, 0, 1, 32'h114, 32'h0000_0020, 32'h1234_5678, 32'h0, 3'd0, 2'd1, 5'd9, 1);
        after_edge();
        chk32("err_one_slot", 32'(bus.wb_addr_err), 32'd0);

        // Link value for a jal.
        issue(0, 0, 0, 1, 32'h3010, 32'h0, 32'h0, 32'h0, 3'd0, 2'd2, 5'd31, 1);
        after_edge();
        chk32("jal_wd", bus.wb_wd, 32'h0000_3018);
        chk32("jal_rfwe", 32'(bus.wb_rfwe), 32'd1);

        // Stall freezes WB for three cycles of changing inputs; stall+flush is a bubble.
        issue_rand(0, 0, 1);
        issue_rand(0, 0, 1);
        issue_rand(0, 0, 1);
        after_edge();
        chk32("stall_hold_wd", bus.wb_wd, 32'h0000_3018);
        issue_rand(0, 1, 1);
        after_edge();
        chk32("flush_pc", bus.wb_pc, 32'h0000_3000);
        chk32("flush_valid", 32'(bus.wb_valid), 32'd0);

        // rd=0 and mem_valid=0 never write.
        issue(0, 0, 0, 1, 32'h200, 32'h0, 32'h0, 32'hDEAD_BEEF, 3'd0, 2'd0, 5'd0, 1);
        after_edge();
        chk32("rd0_wd", bus.wb_wd, 32'hDEAD_BEEF);
        chk32("rd0_rfwe", 32'(bus.wb_rfwe), 32'd0);
        issue(0, 0, 0, 0, 32'h204, 32'h1, 32'h0, 32'h5, 3'd0, 2'd1, 5'd4, 1);
        after_edge();
        chk32("inv_rfwe", 32'(bus.wb_rfwe), 32'd0);
        chk32("inv_err", 32'(bus.wb_addr_err), 32'd0);

        // Random traffic with occasional stall, flush and reset.
        for (int i = 0; i < 400; i++) begin
            issue_rand(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 19) == 0),
                       1'($urandom_range(0, 5) == 0));
        end
        after_edge();
        #5;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
